// File: rtl/gpu_cmd_pkg.sv
// Shared types and field positions for the GPU command sequencer slice.
// Command words: header {opcode, unused, tex}, vertex {x, y}.
package gpu_cmd_pkg;

    localparam int CMD_W   = 32;
    localparam int COORD_W = 16;
    localparam int TEX_W   = 8;
    localparam int WD_W    = 24;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int TEX_MSB = 7;
    localparam int TEX_LSB = 0;
    localparam int X_MSB   = 31;
    localparam int X_LSB   = 16;
    localparam int Y_MSB   = 15;
    localparam int Y_LSB   = 0;

    typedef enum logic [3:0] {
        OP_DRAW       = 4'd0,
        OP_CLEAR_DRAW = 4'd1,
        OP_END        = 4'd2
    } opcode_t;

    typedef enum logic [3:0] {
        ST_HDR        = 4'd0,
        ST_VTX        = 4'd1,
        ST_CLR_REQ    = 4'd2,
        ST_CLR_WAIT   = 4'd3,
        ST_RAS_REQ    = 4'd4,
        ST_RAS_WAIT   = 4'd5,
        ST_FLS_REQ    = 4'd6,
        ST_FLS_WAIT   = 4'd7,
        ST_FRAME_DONE = 4'd8
    } state_t;

    typedef struct packed {
        state_t       state;
        logic [1:0]   vtx_cnt;
        logic [15:0]  tri_cnt;
    } dbg_t;

    function automatic logic is_draw_op(input logic [3:0] op);
        return (op == OP_DRAW) || (op == OP_CLEAR_DRAW);
    endfunction

endpackage

// File: rtl/gpu_cmd_watchdog.sv
// Launch watchdog: counts cycles while enabled and flags expiry at TIMEOUT_CYCLES-1.
// The count freezes once expired so expire stays high until cleared.
module gpu_cmd_watchdog
    import gpu_cmd_pkg::*;
#(
    parameter logic [WD_W-1:0] TIMEOUT_CYCLES = 24'd1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WD_W-1:0] cnt;

    assign expire = enable && (cnt == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + 24'd1;
        end
    end

endmodule

// File: rtl/gpu_cmd_sequencer.sv
// Pops command words from the GPU FIFO and sequences clear, raster and flush
// launches, holding the latched vertex set stable until the consumer is done.
module gpu_cmd_sequencer
    import gpu_cmd_pkg::*;
#(
    parameter logic [WD_W-1:0] TIMEOUT_CYCLES = 24'd1048576
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CMD_W-1:0]   fifo_rdata,
    input  logic               fifo_empty,
    output logic               fifo_read,
    output logic               raster_start,
    input  logic               raster_done,
    output logic [TEX_W-1:0]   tex_num,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x2,
    output logic [COORD_W-1:0] y2,
    output logic [COORD_W-1:0] x3,
    output logic [COORD_W-1:0] y3,
    output logic               clear_start,
    input  logic               clear_done,
    output logic               flush_start,
    input  logic               flush_done,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        frame_tri_count,
    output logic               err_opcode,
    output logic               err_timeout,
    output dbg_t               dbg
);

    state_t      state;
    logic        clr_flag;
    logic [1:0]  vtx_cnt;
    logic [15:0] tri_cnt;
    logic        wd_clear;
    logic        wd_enable;
    logic        wd_expire;
    logic [3:0]  op;

    // FIFO handshake: a word transfers on every cycle with fifo_read && !fifo_empty;
    // fifo_read never looks at fifo_rdata, and nothing is popped while in reset.
    assign fifo_read = !reset && !fifo_empty && ((state == ST_HDR) || (state == ST_VTX));
    assign op        = fifo_rdata[OP_MSB:OP_LSB];

    assign wd_clear  = (state == ST_CLR_REQ) || (state == ST_RAS_REQ) || (state == ST_FLS_REQ);
    assign wd_enable = (state == ST_CLR_WAIT) || (state == ST_RAS_WAIT) || (state == ST_FLS_WAIT);

    assign dbg = '{state: state, vtx_cnt: vtx_cnt, tri_cnt: tri_cnt};

    gpu_cmd_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_HDR;
            clr_flag        <= 1'b0;
            vtx_cnt         <= 2'd0;
            tri_cnt         <= 16'd0;
            tex_num         <= '0;
            x1              <= '0;
            y1              <= '0;
            x2              <= '0;
            y2              <= '0;
            x3              <= '0;
            y3              <= '0;
            raster_start    <= 1'b0;
            clear_start     <= 1'b0;
            flush_start     <= 1'b0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
            frame_tri_count <= 16'd0;
            err_opcode      <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            // Launch pulses are raised on the edge that enters the REQ state.
            raster_start <= 1'b0;
            clear_start  <= 1'b0;
            flush_start  <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b1;

            case (state)
                ST_HDR: begin
                    busy <= 1'b0;
                    if (fifo_read) begin
                        if (is_draw_op(op)) begin
                            tex_num  <= fifo_rdata[TEX_MSB:TEX_LSB];
                            clr_flag <= (op == OP_CLEAR_DRAW);
                            vtx_cnt  <= 2'd0;
                            state    <= ST_VTX;
                            busy     <= 1'b1;
                        end else if (op == OP_END) begin
                            flush_start <= 1'b1;
                            state       <= ST_FLS_REQ;
                            busy        <= 1'b1;
                        end else begin
                            err_opcode <= 1'b1;
                        end
                    end
                end

                ST_VTX: begin
                    if (fifo_read) begin
                        case (vtx_cnt)
                            2'd0: begin
                                x1 <= fifo_rdata[X_MSB:X_LSB];
                                y1 <= fifo_rdata[Y_MSB:Y_LSB];
                            end
                            2'd1: begin
                                x2 <= fifo_rdata[X_MSB:X_LSB];
                                y2 <= fifo_rdata[Y_MSB:Y_LSB];
                            end
                            default: begin
                                x3 <= fifo_rdata[X_MSB:X_LSB];
                                y3 <= fifo_rdata[Y_MSB:Y_LSB];
                            end
                        endcase
                        if (vtx_cnt == 2'd2) begin
                            if (clr_flag) begin
                                clear_start <= 1'b1;
                                state       <= ST_CLR_REQ;
                            end else begin
                                raster_start <= 1'b1;
                                state        <= ST_RAS_REQ;
                            end
                        end else begin
                            vtx_cnt <= vtx_cnt + 2'd1;
                        end
                    end
                end

                ST_CLR_REQ: state <= ST_CLR_WAIT;

                ST_CLR_WAIT: begin
                    if (clear_done) begin
                        raster_start <= 1'b1;
                        state        <= ST_RAS_REQ;
                    end else if (wd_expire) begin
                        err_timeout <= 1'b1;
                        state       <= ST_HDR;
                        busy        <= 1'b0;
                    end
                end

                ST_RAS_REQ: state <= ST_RAS_WAIT;

                ST_RAS_WAIT: begin
                    if (raster_done) begin
                        tri_cnt <= (tri_cnt == 16'hFFFF) ? tri_cnt : tri_cnt + 16'd1;
                        state   <= ST_HDR;
                        busy    <= 1'b0;
                    end else if (wd_expire) begin
                        err_timeout <= 1'b1;
                        state       <= ST_HDR;
                        busy        <= 1'b0;
                    end
                end

                ST_FLS_REQ: state <= ST_FLS_WAIT;

                ST_FLS_WAIT: begin
                    if (flush_done) begin
                        frame_tri_count <= tri_cnt;
                        tri_cnt         <= 16'd0;
                        state           <= ST_FRAME_DONE;
                    end else if (wd_expire) begin
                        // A lost flush still closes the frame's triangle count.
                        tri_cnt     <= 16'd0;
                        err_timeout <= 1'b1;
                        state       <= ST_HDR;
                        busy        <= 1'b0;
                    end
                end

                ST_FRAME_DONE: begin
                    frame_done <= 1'b1;
                    state      <= ST_HDR;
                    busy       <= 1'b0;
                end

                default: begin
                    state <= ST_HDR;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Self-checking bench for gpu_cmd_sequencer: FIFO model, done responders,
// triangle/frame scoreboard and a short-timeout second instance.
module tb_gpu_cmd_sequencer;
    import gpu_cmd_pkg::*;

    localparam int RAS_LAT = 20;
    localparam int CLR_LAT = 6;
    localparam int FLS_LAT = 5;
    localparam int IDLE_BUDGET = 2000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic [31:0] fifo_rdata;
    logic        fifo_empty, fifo_read;
    logic        raster_start, raster_done, clear_start, clear_done, flush_start, flush_done;
    logic [7:0]  tex_num;
    logic [15:0] x1, y1, x2, y2, x3, y3, frame_tri_count;
    logic        busy, frame_done, err_opcode, err_timeout;
    dbg_t        dbg;

    gpu_cmd_sequencer dut (
        .clk(clk), .reset(reset), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .fifo_read(fifo_read), .raster_start(raster_start), .raster_done(raster_done),
        .tex_num(tex_num), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
        .clear_start(clear_start), .clear_done(clear_done), .flush_start(flush_start),
        .flush_done(flush_done), .busy(busy), .frame_done(frame_done),
        .frame_tri_count(frame_tri_count), .err_opcode(err_opcode),
        .err_timeout(err_timeout), .dbg(dbg)
    );

    // ---------------- short-timeout DUT ----------------
    logic [31:0] wd_rdata;
    logic        wd_empty, wd_fifo_read;
    logic        wd_raster_start, wd_raster_done, wd_clear_start, wd_clear_done;
    logic        wd_flush_start, wd_flush_done;
    logic [7:0]  wd_tex_num;
    logic [15:0] wd_x1, wd_y1, wd_x2, wd_y2, wd_x3, wd_y3, wd_frame_tri_count;
    logic        wd_busy, wd_frame_done, wd_err_opcode, wd_err_timeout;
    dbg_t        wd_dbg;

    gpu_cmd_sequencer #(.TIMEOUT_CYCLES(24'd16)) dut_wd (
        .clk(clk), .reset(reset), .fifo_rdata(wd_rdata), .fifo_empty(wd_empty),
        .fifo_read(wd_fifo_read), .raster_start(wd_raster_start), .raster_done(wd_raster_done),
        .tex_num(wd_tex_num), .x1(wd_x1), .y1(wd_y1), .x2(wd_x2), .y2(wd_y2), .x3(wd_x3), .y3(wd_y3),
        .clear_start(wd_clear_start), .clear_done(wd_clear_done), .flush_start(wd_flush_start),
        .flush_done(wd_flush_done), .busy(wd_busy), .frame_done(wd_frame_done),
        .frame_tri_count(wd_frame_tri_count), .err_opcode(wd_err_opcode),
        .err_timeout(wd_err_timeout), .dbg(wd_dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [104:0] exp_q[$];     // {clr, tex, x1, y1, x2, y2, x3, y3}
    logic [15:0]  frame_q[$];
    logic [104:0] exp_e;
    int model_tri;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [31:0] word_q[$];
    bit          hdr_q[$];
    int          stall_q[$];
    int          hold;
    bit          pend_pop;

    function automatic void fifo_refresh();
        fifo_rdata = (word_q.size() > 0) ? word_q[0] : 32'h0;
        fifo_empty = (word_q.size() == 0) || (hold > 0);
    endfunction

    always @(posedge clk) begin
        #1;
        if (pend_pop && word_q.size() > 0) begin
            void'(word_q.pop_front());
            void'(hdr_q.pop_front());
            void'(stall_q.pop_front());
            hold = (stall_q.size() > 0) ? stall_q[0] : 0;
        end else if (hold > 0) begin
            hold--;
        end
        fifo_refresh();
    end

    task automatic push_word(input logic [31:0] w, input bit is_hdr, input int stall);
        word_q.push_back(w);
        hdr_q.push_back(is_hdr);
        stall_q.push_back(stall);
        fifo_refresh();
    endtask

    // s1/s2: cycles the FIFO looks empty before vertex 2 / vertex 3 appear
    task automatic push_tri(input logic [3:0] op, input logic [7:0] tex,
                            input logic [95:0] c, input int s1, input int s2);
        push_word({op, 20'h0, tex}, 1'b1, 0);
        push_word(c[95:64], 1'b0, 0);
        push_word(c[63:32], 1'b0, s1);
        push_word(c[31:0], 1'b0, s2);
        exp_q.push_back({(op == 4'd1), tex, c});
        model_tri++;
    endtask

    task automatic push_end();
        push_word({4'd2, 28'h0}, 1'b1, 0);
        frame_q.push_back(16'(model_tri));
        model_tri = 0;
    endtask

    function automatic logic [95:0] rand_coords();
        logic [95:0] c;
        for (int i = 0; i < 6; i++) c[i*16 +: 16] = 16'($urandom_range(0, 65535));
        return c;
    endfunction

    // ---------------- monitor + done responders ----------------
    int  cyc = 0;
    int  hdr_cyc = 0;
    int  clr_due = -1, ras_due = -1, fls_due = -1;
    int  clr_done_cyc = -100, fls_done_cyc = -100;
    int  rs_cnt = 0;
    bit  clear_seen, chk_lat;

    always @(negedge clk) begin
        cyc++;
        pend_pop = fifo_read && !fifo_empty;
        if (pend_pop && hdr_q.size() > 0 && hdr_q[0]) hdr_cyc = cyc;
        raster_done = 1'b0;
        clear_done  = 1'b0;
        flush_done  = 1'b0;
        if (!reset) begin
            if (clear_start) begin
                check("clear_only_for_clear_draw", (exp_q.size() > 0) ? exp_q[0][104] : 1'b0, 1'b1);
                clear_seen = 1'b1;
                clr_due = cyc + CLR_LAT;
            end
            if (raster_start) begin
                rs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_raster_start", 1'b1, 1'b0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("tri_tex_coords", {tex_num, x1, y1, x2, y2, x3, y3}, exp_e[103:0]);
                    if (exp_e[104])
                        check("raster_after_clear_done", {clear_seen, 32'(cyc - clr_done_cyc)}, {1'b1, 32'd1});
                    if (chk_lat)
                        check("raster_start_latency", 32'(cyc - hdr_cyc), 32'd4);
                end
                clear_seen = 1'b0;
                ras_due = cyc + RAS_LAT;
            end
            if (flush_start) fls_due = cyc + FLS_LAT;
            if (frame_done) begin
                if (frame_q.size() == 0) begin
                    check("unexpected_frame_done", 1'b1, 1'b0);
                end else begin
                    check("frame_tri_count", frame_tri_count, frame_q.pop_front());
                    check("frame_done_latency", 32'(cyc - fls_done_cyc), 32'd2);
                end
            end
            if (cyc == clr_due) begin clear_done = 1'b1; clr_done_cyc = cyc; end
            if (cyc == ras_due) raster_done = 1'b1;
            if (cyc == fls_due) begin flush_done = 1'b1; fls_done_cyc = cyc; end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_bench();
        word_q.delete(); hdr_q.delete(); stall_q.delete();
        hold = 0;
        exp_q.delete(); frame_q.delete();
        model_tri = 0;
        clr_due = -1; ras_due = -1; fls_due = -1;
        clear_seen = 1'b0; chk_lat = 1'b0;
        fifo_refresh();
        wd_rdata = 32'h0; wd_empty = 1'b1;
        wd_raster_done = 1'b0; wd_clear_done = 1'b0; wd_flush_done = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_bench();
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        tick(2);
        while ((word_q.size() > 0 || exp_q.size() > 0 || frame_q.size() > 0 || busy) && n < IDLE_BUDGET) begin
            tick(1);
            n++;
        end
        check({tag, "_completes"}, (n < IDLE_BUDGET), 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, {raster_start, clear_start, flush_start, frame_done, busy, fifo_read}, 6'h0);
        check({tag, "_vertex"}, {tex_num, x1, y1, x2, y2, x3, y3}, 104'h0);
        check({tag, "_status"}, {frame_tri_count, err_opcode, err_timeout, dbg}, '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int n;
        int rs_before;
        bit prev_busy;
        logic [31:0] wd_words [4];
        logic [95:0] c;

        reset = 1'b1;
        clear_bench();
        pend_pop = 1'b0;

        // reset state
        apply_reset();
        check_all_zero("reset");

        // single DRAW with exact latency and busy release
        chk_lat = 1'b1;
        push_tri(4'd0, 8'd1, {16'd10, 16'd10, 16'd10, 16'd110, 16'd110, 16'd10}, 0, 0);
        n = 0;
        prev_busy = 1'b0;
        while (!raster_done && n < 200) begin
            prev_busy = busy;
            tick(1);
            n++;
        end
        check("draw_raster_done_seen", (n < 200), 1'b1);
        check("draw_busy_before_done", prev_busy, 1'b1);
        check("draw_busy_after_done", busy, 1'b0);
        check("draw_tri_cnt", dbg.tri_cnt, 16'd1);
        chk_lat = 1'b0;
        wait_idle("draw");

        // CLEAR_DRAW then END
        apply_reset();
        push_tri(4'd1, 8'd1, rand_coords(), 0, 0);
        push_end();
        wait_idle("clear_draw_end");
        check("clear_draw_tri_reset", dbg.tri_cnt, 16'd0);

        // three DRAWs with a 5-cycle FIFO stall between vertex 1 and 2
        apply_reset();
        push_tri(4'd0, 8'd2, rand_coords(), 5, 0);
        push_tri(4'd0, 8'd3, rand_coords(), 0, 0);
        push_tri(4'd0, 8'd3, rand_coords(), 0, 0);
        push_end();
        wait_idle("stall_three_draws");
        check("stall_no_timeout", err_timeout, 1'b0);

        // illegal opcode dropped, following DRAW completes
        apply_reset();
        push_word(32'hF000_0000, 1'b1, 0);
        push_tri(4'd0, 8'h44, rand_coords(), 0, 0);
        push_end();
        wait_idle("illegal_then_draw");
        check("illegal_err_opcode", err_opcode, 1'b1);
        check("illegal_no_timeout", err_timeout, 1'b0);

        // random mix of DRAW / CLEAR_DRAW with short stalls
        apply_reset();
        for (int i = 0; i < 5; i++)
            push_tri(4'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rand_coords(),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        push_end();
        wait_idle("random_mix");
        check("random_errors_clean", {err_opcode, err_timeout}, 2'b00);

        // watchdog on the 16-cycle instance: raster_done never arrives
        apply_reset();
        wd_words = '{{4'd0, 20'h0, 8'h07}, 32'h0001_0002, 32'h0003_0004, 32'h0005_0006};
        for (int i = 0; i < 4; i++) begin
            wd_rdata = wd_words[i];
            wd_empty = 1'b0;
            tick(1);
        end
        wd_empty = 1'b1;
        n = 0;
        while (!wd_raster_start && n < 10) begin tick(1); n++; end
        check("wd_raster_start_seen", (n < 10), 1'b1);
        tick(15);
        check("wd_before_expiry", {wd_err_timeout, wd_dbg.state}, {1'b0, ST_RAS_WAIT});
        tick(2);
        check("wd_err_timeout", wd_err_timeout, 1'b1);
        check("wd_state_hdr", wd_dbg.state, ST_HDR);
        check("wd_tri_unchanged", wd_dbg.tri_cnt, 16'd0);
        check("wd_busy_low", wd_busy, 1'b0);

        // reset in VTX after two vertices
        apply_reset();
        push_tri(4'd0, 8'h09, rand_coords(), 0, 1000);
        n = 0;
        while (word_q.size() > 1 && n < 50) begin tick(1); n++; end
        tick(2);
        check("mid_reset_in_vtx", {dbg.state, dbg.vtx_cnt}, {ST_VTX, 2'd2});
        rs_before = rs_cnt;
        reset = 1'b1;
        tick(1);
        check_all_zero("mid_reset");
        clear_bench();
        reset = 1'b0;
        tick(30);
        check("mid_reset_no_raster", rs_cnt, rs_before);
        push_tri(4'd0, 8'h0A, rand_coords(), 0, 0);
        push_end();
        wait_idle("after_mid_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : global_guard
        #400000;
        $display("FAIL global_time_limit actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/gpu_cmd_sequencer.md
# gpu_cmd_sequencer

Command sequencer between the GPU command FIFO and the drawing datapath. It pops 32-bit command words and decodes draw, clear-then-draw and end-of-frame commands. It launches the framebuffer clear engine, the triangle rasterizer or the SDRAM frame-flush engine in order, and holds each vertex set stable until the consumer finishes. A watchdog guards every launch against a hung datapath.

## Interface
- TIMEOUT_CYCLES, 24'd1048576, max cycles to wait for any `*_done` before abort
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- fifo_rdata  in  32  show-ahead FIFO head word
- fifo_empty  in  1  FIFO has no word
- fifo_read  out  1  pop strobe; word consumed when fifo_read && !fifo_empty
- raster_start  out  1  one-cycle launch pulse to rasterizer
- raster_done  in  1  one-cycle completion pulse
- tex_num  out  8  texture index for current triangle
- x1, y1, x2, y2, x3, y3  out  16 each  vertex coordinates
- clear_start / clear_done  out / in  1  framebuffer clear handshake (pulses)
- flush_start / flush_done  out / in  1  framebuffer-to-SDRAM flush handshake (pulses)
- busy  out  1  high in any state but HDR
- frame_done  out  1  one-cycle pulse after flush_done
- frame_tri_count  out  16  triangles drawn in last completed frame
- err_opcode  out  1  sticky: illegal opcode seen
- err_timeout  out  1  sticky: watchdog expired

## Operation
- Header word: opcode[31:28], [27:8] ignored, tex[7:0]. Vertex word: x[31:16], y[15:0].
- Opcodes: 0 DRAW, 1 CLEAR_DRAW, 2 END; 3–15 illegal.
- States: HDR, VTX, CLR_REQ, CLR_WAIT, RAS_REQ, RAS_WAIT, FLS_REQ, FLS_WAIT, FRAME_DONE.
- HDR: fifo_read = !fifo_empty. On pop:
  - DRAW or CLEAR_DRAW: latch tex_num and clr flag, clear vtx_cnt, go to VTX.
  - END: go to FLS_REQ.
  - Illegal: set err_opcode, drop the word, stay in HDR.
- VTX: fifo_read = !fifo_empty. Each pop latches vertex vtx_cnt (0→x1/y1, 1→x2/y2, 2→x3/y3). After the third pop, go to CLR_REQ if clr is set, else RAS_REQ.
- CLR_REQ: pulse clear_start, go to CLR_WAIT. CLR_WAIT: on clear_done go to RAS_REQ.
- RAS_REQ: pulse raster_start, go to RAS_WAIT. RAS_WAIT: on raster_done, tri_cnt++ (saturates at 16'hFFFF), go to HDR.
- FLS_REQ: pulse flush_start, go to FLS_WAIT. FLS_WAIT: on flush_done, latch frame_tri_count = tri_cnt, clear tri_cnt, go to FRAME_DONE.
- FRAME_DONE: pulse frame_done, go to HDR.
- Watchdog: counter clears on entry to each *_WAIT state and increments while in it. At TIMEOUT_CYCLES−1 without a done pulse: set err_timeout, go to HDR, and do not increment tri_cnt. In FLS_WAIT a timeout still clears tri_cnt.
- `*_done` is ignored outside its matching WAIT state, including in the REQ cycle.
- tex_num and x1..y3 change only on a VTX/HDR pop, so they are stable from raster_start through raster_done.
- Sticky errors clear only on reset.

## Timing
- Reset: state HDR. All outputs 0, including tex_num, coordinates, frame_tri_count, errors and counters.
- fifo_read is combinational from state and fifo_empty. All other outputs are registered.
- With the FIFO never empty, header popped at cycle T:
  - vertices at T+1, T+2, T+3; raster_start at T+4.
  - CLEAR_DRAW: clear_start at T+4; raster_start 1 cycle after the clear_done cycle.
  - The next header pops the cycle after raster_done.
  - END popped at T: flush_start at T+1; frame_done 2 cycles after flush_done.
- fifo_empty during VTX stalls without losing vtx_cnt. There is no timeout on FIFO stalls.
- Reset mid-operation aborts immediately. The partially collected triangle is discarded and no further start is issued.

## Structure
- gpu_cmd_pkg: opcode enum (OP_DRAW, OP_CLEAR_DRAW, OP_END), state enum, field bit positions, coordinate width 16, tex width 8.
- One submodule: gpu_cmd_watchdog (clear, enable, expire; parameter TIMEOUT_CYCLES).

## Test plan
- DRAW tex 1, (10,10)(10,110)(110,10), FIFO pre-filled, raster_done 20 cycles after start:
  - raster_start exactly 4 cycles after the header pop, with the exact coordinates;
  - tri_cnt becomes 1; busy drops the cycle after raster_done.
- CLEAR_DRAW tex 1 then END:
  - clear_start precedes raster_start, and raster_start comes only after clear_done;
  - flush_start fires, frame_done pulses, frame_tri_count=1.
- Three DRAWs (tex 2, 3, 3) with fifo_empty held 5 cycles between vertex 1 and vertex 2:
  - the stall is tolerated and vertices latch correctly;
  - after END, frame_tri_count=3.
- Header opcode 4'hF, then a valid DRAW: err_opcode=1, the bad word is dropped, and the DRAW completes normally.
- TIMEOUT_CYCLES=16 with raster_done never asserted:
  - err_timeout=1 at cycle 16 of RAS_WAIT, state returns to HDR, tri_cnt is unchanged.
- Reset asserted in VTX after 2 vertices:
  - all outputs are 0 next cycle and no raster_start follows;
  - a fresh DRAW then succeeds.
